// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM encoding,
// depth helper and flattened-bus slice macro.
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Port idx of a flattened bus whose ports are w bits wide.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_e;

  function automatic int unsigned rf_depth(input int unsigned addr_len);
    return 32'd1 << addr_len;
  endfunction

endpackage

`endif

// File: rtl/regfile_clr_seq.sv
// Clear engine: on a clr pulse in IDLE, drops all valid bits and then sweeps
// zeros through every array entry, one per cycle.
//
// state    | meaning
// ST_IDLE  | normal operation, writes accepted, clr starts a sweep
// ST_SWEEP | busy; zeroing array[cnt], writes dropped, clr ignored
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int addrLen = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  output logic               busy,
  output logic               clrAll,
  output logic               sweepWe,
  output logic [addrLen-1:0] sweepAddr
);

  clr_state_e         state, state_nxt;
  logic [addrLen-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clrAll    = 1'b0;
    sweepWe   = 1'b0;
    sweepAddr = cnt;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          clrAll    = 1'b1;
          state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        busy    = 1'b1;
        sweepWe = 1'b1;
        // counter wraps to zero naturally on the last entry
        cnt_nxt = cnt + 1'b1;
        if (cnt == {addrLen{1'b1}}) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file with per-entry valid bits, optional registered
// reads with write bypass, and a sequenced clear.
module mp_regfile
  import regfile_pkg::*;
#(
  parameter int addrLen   = 5,
  parameter int dataLen   = 32,
  parameter int numRd     = 2,
  parameter int numWr     = 2,
  parameter int rdLatency = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  output logic                     busy,
  input  logic [numWr-1:0]         wrt,
  input  logic [numWr*addrLen-1:0] wrtAddr,
  input  logic [numWr*dataLen-1:0] dataIn,
  input  logic [numRd-1:0]         rd,
  input  logic [numRd*addrLen-1:0] rdAddr,
  output logic [numRd*dataLen-1:0] dataOut,
  output logic [numRd-1:0]         rdValid
);

  localparam int DEPTH = rf_depth(addrLen);

  logic [dataLen-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [numWr-1:0]   wr_acc;
  logic               clrAll;
  logic               sweepWe;
  logic [addrLen-1:0] sweepAddr;

  regfile_clr_seq #(.addrLen(addrLen)) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .busy      (busy),
    .clrAll    (clrAll),
    .sweepWe   (sweepWe),
    .sweepAddr (sweepAddr)
  );

  assign wr_acc = busy ? '0 : wrt;

  // Ascending port order: the last assignment, i.e. highest port, wins.
  always_ff @(posedge clk) begin
    if (sweepWe) mem[sweepAddr] <= '0;
    for (int j = 0; j < numWr; j++) begin
      if (wr_acc[j]) mem[`RF_SLICE(wrtAddr, j, addrLen)] <= `RF_SLICE(dataIn, j, dataLen);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (clrAll) begin
      valid <= '0;
    end else begin
      for (int j = 0; j < numWr; j++) begin
        if (wr_acc[j]) valid[`RF_SLICE(wrtAddr, j, addrLen)] <= 1'b1;
      end
    end
  end

  generate
    if (rdLatency == 1) begin : g_reg_rd
      logic [numRd-1:0]         byp_hit;
      logic [numRd*dataLen-1:0] byp_data;
      logic [numRd*dataLen-1:0] dout_q;
      logic [numRd-1:0]         rv_q;

      always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        for (int i = 0; i < numRd; i++) begin
          for (int j = 0; j < numWr; j++) begin
            if (wr_acc[j] && (`RF_SLICE(wrtAddr, j, addrLen) == `RF_SLICE(rdAddr, i, addrLen))) begin
              byp_hit[i] = 1'b1;
              `RF_SLICE(byp_data, i, dataLen) = `RF_SLICE(dataIn, j, dataLen);
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dout_q <= '0;
          rv_q   <= '0;
        end else begin
          for (int i = 0; i < numRd; i++) begin
            if (rd[i]) begin
              if (byp_hit[i]) begin
                `RF_SLICE(dout_q, i, dataLen) <= `RF_SLICE(byp_data, i, dataLen);
                rv_q[i]                       <= 1'b1;
              end else begin
                `RF_SLICE(dout_q, i, dataLen) <= mem[`RF_SLICE(rdAddr, i, addrLen)];
                rv_q[i]                       <= valid[`RF_SLICE(rdAddr, i, addrLen)];
              end
            end
          end
        end
      end

      assign dataOut = dout_q;
      assign rdValid = rv_q;
    end else begin : g_comb_rd
      logic rd_unused;
      assign rd_unused = ^rd;

      always_comb begin
        dataOut = '0;
        rdValid = '0;
        for (int i = 0; i < numRd; i++) begin
          `RF_SLICE(dataOut, i, dataLen) = mem[`RF_SLICE(rdAddr, i, addrLen)];
          rdValid[i]                     = valid[`RF_SLICE(rdAddr, i, addrLen)];
        end
      end
    end
  endgenerate

endmodule
